// File: rtl/jac_pc_pkg.sv
// Shared definitions for the Jac1 program counter: default widths,
// reset address and the per-cycle update selection.
package jac_pc_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 8;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam logic [PC_WIDTH_DEF-1:0] RESET_PC_DEF = {PC_WIDTH_DEF{1'b1}};

  // Which pc update happens on the next edge, after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_JUMP,
    OP_INC
  } pc_op_e;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Decoder-to-program-counter bus: control strobes and target in,
// pc and stack status out.
interface program_counter_stack_if
  import jac_pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
);

  localparam int unsigned DEPTH_W = clog2(STACK_DEPTH + 1);

  logic                stall;
  logic                wr_en;
  logic                add_offset;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] counteradress;
  logic [PC_WIDTH-1:0] pc;
  logic [DEPTH_W-1:0]  sp_depth;
  logic                stack_empty;
  logic                stack_full;
  logic                ovf_err;
  logic                unf_err;

  // Instruction decoder side.
  modport master (
    output stall, wr_en, add_offset, call, ret, counteradress,
    input  pc, sp_depth, stack_empty, stack_full, ovf_err, unf_err
  );

  // Program counter side.
  modport slave (
    input  stall, wr_en, add_offset, call, ret, counteradress,
    output pc, sp_depth, stack_empty, stack_full, ovf_err, unf_err
  );

endinterface

// File: rtl/return_stack.sv
// Return-address LIFO. Push while full and pop while empty are dropped;
// if both strobes arrive together the pop wins.
module return_stack
  import jac_pc_pkg::*;
#(
  parameter int unsigned WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned DEPTH   = STACK_DEPTH_DEF,
  parameter int unsigned DEPTH_W = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (depth == DEPTH_W'(DEPTH));
  assign empty   = (depth == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;

  // Stack pointer: number of valid entries.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      depth <= '0;
    end else if (do_pop) begin
      depth <= depth - DEPTH_W'(1);
    end else if (do_push) begin
      depth <= depth + DEPTH_W'(1);
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_push && (DEPTH_W'(i) == depth)) mem[i] <= din;
    end
  end

  // Top-of-stack read, zero when empty.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth) dout = mem[i];
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Jac1 program counter: increment, absolute/relative jump, call/return
// through a hardware return stack, stall hold and sticky stack errors.
module program_counter_stack
  import jac_pc_pkg::*;
#(
  parameter int unsigned       PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '1
) (
  input  logic                    clk,
  input  logic                    res,
  program_counter_stack_if.slave  bus
);

  localparam int unsigned DEPTH_W = clog2(STACK_DEPTH + 1);

  pc_op_e              op;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] stack_top;
  logic [DEPTH_W-1:0]  depth;
  logic                full;
  logic                empty;
  logic                ovf_q;
  logic                unf_q;

  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign target = bus.add_offset ? (pc_q + bus.counteradress) : bus.counteradress;

  // Resolve strobes in priority order: stall, ret, call, jump, increment.
  always_comb begin
    op = OP_INC;
    if (bus.stall)      op = OP_HOLD;
    else if (bus.ret)   op = OP_RET;
    else if (bus.call)  op = OP_CALL;
    else if (bus.wr_en) op = OP_JUMP;
  end

  return_stack #(
    .WIDTH   (PC_WIDTH),
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk   (clk),
    .res   (res),
    .push  (op == OP_CALL),
    .pop   (op == OP_RET),
    .din   (pc_inc),
    .dout  (stack_top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Program counter and sticky error flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (op)
        OP_RET: begin
          if (empty) begin
            pc_q  <= pc_inc;
            unf_q <= 1'b1;
          end else begin
            pc_q <= stack_top;
          end
        end
        OP_CALL: begin
          pc_q <= target;
          if (full) ovf_q <= 1'b1;
        end
        OP_JUMP: pc_q <= target;
        OP_INC:  pc_q <= pc_inc;
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp_depth    = depth;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Bench for program_counter_stack (PC_WIDTH=8, STACK_DEPTH=4): directed
// scenarios plus randomized strobes against a queue-based reference model.
module tb_program_counter_stack;
  import jac_pc_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned SD = 4;

  logic clk = 1'b0;
  logic res;

  program_counter_stack_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus_if ();

  program_counter_stack #(
    .PC_WIDTH    (PW),
    .STACK_DEPTH (SD),
    .RESET_PC    (8'hFF)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_ovf;
  logic       m_unf;

  int total  = 0;
  int passed = 0;

  function automatic void model_reset();
    m_pc = 8'hFF;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(input logic st, input logic rt, input logic cl,
                                     input logic wr, input logic ao, input logic [7:0] ca);
    logic [7:0] tgt;
    logic [7:0] nxt;
    if (st) return;
    tgt = ao ? m_pc + ca : ca;
    nxt = m_pc + 8'd1;
    if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = nxt;
        m_unf = 1'b1;
      end
    end else if (cl) begin
      if (m_stack.size() < SD) m_stack.push_back(nxt);
      else m_ovf = 1'b1;
      m_pc = tgt;
    end else if (wr) begin
      m_pc = tgt;
    end else begin
      m_pc = nxt;
    end
  endfunction

  function automatic logic [14:0] observed();
    return {bus_if.pc, bus_if.sp_depth, bus_if.stack_empty, bus_if.stack_full,
            bus_if.ovf_err, bus_if.unf_err};
  endfunction

  function automatic logic [14:0] expected();
    logic [2:0] d;
    d = 3'(m_stack.size());
    return {m_pc, d, (d == 3'd0), (d == 3'(SD)), m_ovf, m_unf};
  endfunction

  task automatic set_strobes(input logic st, input logic rt, input logic cl,
                             input logic wr, input logic ao, input logic [7:0] ca);
    bus_if.stall         = st;
    bus_if.ret           = rt;
    bus_if.call          = cl;
    bus_if.wr_en         = wr;
    bus_if.add_offset    = ao;
    bus_if.counteradress = ca;
  endtask

  // Drive strobes, take one edge, advance the model, settle 1 time unit.
  task automatic step(input logic st, input logic rt, input logic cl,
                      input logic wr, input logic ao, input logic [7:0] ca);
    set_strobes(st, rt, cl, wr, ao, ca);
    @(posedge clk);
    model_step(st, rt, cl, wr, ao, ca);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'h00; exp_pc[1] = 8'h01; exp_pc[2] = 8'h02;
    res = 1'b1;
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    #2;
    total++;
    if (bus_if.pc !== 8'hFF) $display("FAIL reset_pc: got %h expected ff", bus_if.pc);
    else passed++;
    total++;
    if (bus_if.sp_depth !== 3'd0 || bus_if.stack_empty !== 1'b1 || bus_if.stack_full !== 1'b0)
      $display("FAIL reset_stack: depth %0d empty %b full %b expected 0 1 0",
               bus_if.sp_depth, bus_if.stack_empty, bus_if.stack_full);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (observed() !== expected()) $display("FAIL reset_hold: got %h expected %h", observed(), expected());
    else passed++;
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (bus_if.pc !== exp_pc[i] || observed() !== expected())
        $display("FAIL release_inc%0d: got pc %h expected %h", i, bus_if.pc, exp_pc[i]);
      else passed++;
    end
  endtask

  task automatic test_branch();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0);
    total++;
    if (bus_if.pc !== 8'h00) $display("FAIL branch_back: got %h expected 00", bus_if.pc);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03);
    total++;
    if (bus_if.pc !== 8'h01) $display("FAIL branch_wrap: got %h expected 01", bus_if.pc);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7A);
    total++;
    if (bus_if.pc !== 8'h7A || observed() !== expected())
      $display("FAIL branch_abs: got %h expected 7a", bus_if.pc);
    else passed++;
  endtask

  task automatic test_call_return();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
    total++;
    if (bus_if.pc !== 8'h40 || bus_if.sp_depth !== 3'd1)
      $display("FAIL call: got pc %h depth %0d expected 40 1", bus_if.pc, bus_if.sp_depth);
    else passed++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (bus_if.pc !== 8'h13 || bus_if.sp_depth !== 3'd0 || bus_if.stack_empty !== 1'b1)
      $display("FAIL ret: got pc %h depth %0d empty %b expected 13 0 1",
               bus_if.pc, bus_if.sp_depth, bus_if.stack_empty);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] dest [5];
    logic [7:0] ret_addr [4];
    dest[0] = 8'h50; dest[1] = 8'h60; dest[2] = 8'h70; dest[3] = 8'h80; dest[4] = 8'h90;
    ret_addr[0] = 8'h71; ret_addr[1] = 8'h61; ret_addr[2] = 8'h51; ret_addr[3] = 8'h14;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dest[i]);
    total++;
    if (bus_if.pc !== 8'h90 || bus_if.sp_depth !== 3'd4 || bus_if.stack_full !== 1'b1 ||
        bus_if.ovf_err !== 1'b1)
      $display("FAIL overflow: got pc %h depth %0d full %b ovf %b expected 90 4 1 1",
               bus_if.pc, bus_if.sp_depth, bus_if.stack_full, bus_if.ovf_err);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (bus_if.pc !== ret_addr[i] || observed() !== expected())
        $display("FAIL unwind%0d: got pc %h expected %h", i, bus_if.pc, ret_addr[i]);
      else passed++;
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (bus_if.pc !== 8'h21 || bus_if.unf_err !== 1'b1)
      $display("FAIL underflow: got pc %h unf %b expected 21 1", bus_if.pc, bus_if.unf_err);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (bus_if.unf_err !== 1'b1) $display("FAIL unf_sticky: got %b expected 1", bus_if.unf_err);
    else passed++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    total++;
    if (bus_if.pc !== 8'h23 || bus_if.sp_depth !== 3'd0 || observed() !== expected())
      $display("FAIL call_ret: got pc %h depth %0d expected 23 0", bus_if.pc, bus_if.sp_depth);
    else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] pc_before;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
    pc_before = m_pc;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
    total++;
    if (bus_if.pc !== pc_before || bus_if.sp_depth !== 3'd1)
      $display("FAIL stall_call: got pc %h depth %0d expected %h 1", bus_if.pc, bus_if.sp_depth, pc_before);
    else passed++;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05);
    total++;
    if (observed() !== expected()) $display("FAIL stall_ret: got %h expected %h", observed(), expected());
    else passed++;
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB0);
    total++;
    if (bus_if.sp_depth !== 3'd3) $display("FAIL pre_reset_depth: got %0d expected 3", bus_if.sp_depth);
    else passed++;
    // call strobe still asserted: its push must never happen
    #2;
    res = 1'b1;
    #1;
    total++;
    if (bus_if.pc !== 8'hFF || bus_if.sp_depth !== 3'd0 || bus_if.ovf_err !== 1'b0 ||
        bus_if.unf_err !== 1'b0)
      $display("FAIL reset_mid: got pc %h depth %0d ovf %b unf %b expected ff 0 0 0",
               bus_if.pc, bus_if.sp_depth, bus_if.ovf_err, bus_if.unf_err);
    else passed++;
    @(negedge clk);
    set_strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    res = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (bus_if.pc !== 8'h00 || observed() !== expected())
      $display("FAIL after_reset: got pc %h expected 00", bus_if.pc);
    else passed++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(2) == 0), 1'($urandom_range(1)), 8'($urandom));
      total++;
      if (observed() !== expected()) begin
        if (bad < 10) $display("FAIL random%0d: got %h expected %h", i, observed(), expected());
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_return();
    test_overflow();
    test_underflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
